lcd_dma: RTL and testbench

- CPU-programmed DMA engine that copies blocks from the system bus into VRAM.
- It is the write side of the VRAM that the LCD video scanner reads.
- Sits between the CPU register decode (0x2008–0x200D), the system memory bus and the VRAM write port.
- Holds the CPU via `busy` while a transfer runs.

---
 rtl/sv_pkg.sv | 35 +++
 rtl/lcd_dma_regs.sv | 104 ++++++++++
 rtl/lcd_dma.sv | 151 +++++++++++++++
 tb/tb_lcd_dma.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sv_pkg.sv
// ---------------------------------------------------------------------------
// sv_pkg: definitions shared by lcd_dma and lcd_dma_regs.
//   - CPU register indices (src/dst/len/ctrl)
//   - UNIT_BYTES: bytes moved per unit of the length register
//   - DMA engine FSM state encoding
//   - byte_count(): converts a length register value into a byte count
// ---------------------------------------------------------------------------
package sv_pkg;

    localparam int UNIT_BYTES = 16;

    localparam logic [2:0] DMA_SRC_LO = 3'd0;
    localparam logic [2:0] DMA_SRC_HI = 3'd1;
    localparam logic [2:0] DMA_DST_LO = 3'd2;
    localparam logic [2:0] DMA_DST_HI = 3'd3;
    localparam logic [2:0] DMA_LEN    = 3'd4;
    localparam logic [2:0] DMA_CTRL   = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } dma_state_e;

    // len = 0 encodes 256 units, so the largest count (4096) still fits in
    // the 13-bit down-counter.
    function automatic logic [12:0] byte_count(input logic [7:0] len);
        logic [12:0] units;
        units = (len == 8'd0) ? 13'd256 : {5'd0, len};
        return units * 13'(UNIT_BYTES);
    endfunction

endpackage

// File: rtl/lcd_dma_regs.sv
// ---------------------------------------------------------------------------
// lcd_dma_regs: CPU-visible register file of the LCD DMA engine.
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   ce_i               clock enable
//   reg_cs_i/we_i      register select / write strobe
//   reg_addr_i/din_i   register index / write data
//   idle_i             engine is idle; writes are accepted only then
//   busy_i             transfer active (read back through ctrl bit 7)
//   step_i             one byte moved: advance src and dst
//   src_o              current source address
//   vram_dst_o         current VRAM destination address (low bits of dst)
//   len_o              length in units
//   start_o            ctrl write with bit 7 set while idle
//   reg_dout_o         combinational readback
// ---------------------------------------------------------------------------
module lcd_dma_regs
    import sv_pkg::*;
#(
    parameter int VRAM_AW = 13
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               ce_i,
    input  logic               reg_cs_i,
    input  logic               reg_we_i,
    input  logic [2:0]         reg_addr_i,
    input  logic [7:0]         reg_din_i,
    input  logic               idle_i,
    input  logic               busy_i,
    input  logic               step_i,
    output logic [15:0]        src_o,
    output logic [VRAM_AW-1:0] vram_dst_o,
    output logic [7:0]         len_o,
    output logic               start_o,
    output logic [7:0]         reg_dout_o
);

    logic [15:0]        src_q, src_d;
    logic [15:0]        dst_q, dst_d;
    logic [7:0]         len_q, len_d;
    logic               wr_en_s;
    logic [VRAM_AW-1:0] dst_low_inc_s;

    // CPU writes land only while the engine is idle (this also blocks a second start).
    assign wr_en_s       = ce_i & reg_cs_i & reg_we_i & idle_i;
    // dst wraps inside the VRAM window; upper dst bits are left untouched.
    assign dst_low_inc_s = dst_q[VRAM_AW-1:0] + VRAM_AW'(1);

    assign start_o    = wr_en_s & (reg_addr_i == DMA_CTRL) & reg_din_i[7];
    assign src_o      = src_q;
    assign vram_dst_o = dst_q[VRAM_AW-1:0];
    assign len_o      = len_q;

    // Next-state for the address/length registers: engine stepping or CPU write.
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        len_d = len_q;
        if (step_i) begin
            src_d = src_q + 16'd1;
            dst_d = {dst_q[15:VRAM_AW], dst_low_inc_s};
        end else if (wr_en_s) begin
            case (reg_addr_i)
                DMA_SRC_LO: src_d[7:0]  = reg_din_i;
                DMA_SRC_HI: src_d[15:8] = reg_din_i;
                DMA_DST_LO: dst_d[7:0]  = reg_din_i;
                DMA_DST_HI: dst_d[15:8] = reg_din_i;
                DMA_LEN:    len_d       = reg_din_i;
                default:    len_d       = len_q;
            endcase
        end else begin
            len_d = len_q;
        end
    end

    // Register state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            src_q <= 16'h0000;
            dst_q <= 16'h0000;
            len_q <= 8'h00;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            len_q <= len_d;
        end
    end

    // Readback mux; indices 6 and 7 read as zero.
    always_comb begin
        reg_dout_o = 8'h00;
        case (reg_addr_i)
            DMA_SRC_LO: reg_dout_o = src_q[7:0];
            DMA_SRC_HI: reg_dout_o = src_q[15:8];
            DMA_DST_LO: reg_dout_o = dst_q[7:0];
            DMA_DST_HI: reg_dout_o = dst_q[15:8];
            DMA_LEN:    reg_dout_o = len_q;
            DMA_CTRL:   reg_dout_o = {busy_i, 7'b0000000};
            default:    reg_dout_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/lcd_dma.sv
// ---------------------------------------------------------------------------
// lcd_dma: CPU-programmed DMA engine copying blocks from the system bus into
// VRAM (write side of the VRAM read by the LCD scanner).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   ce                           clock enable for all state
//   reg_cs/reg_we/reg_addr/...   CPU register interface (indices 0..5)
//   reg_dout                     combinational register readback
//   busy                         transfer active (CPU halt request)
//   done                         one-clk pulse at transfer completion
//   mem_addr/mem_rd/mem_din      system bus read port
//   vram_addr/vram_dout/vram_we  VRAM write port
// Each byte takes three ce ticks: READ (mem_rd high), CAPTURE (data
// latched), WRITE (vram_we high).
// ---------------------------------------------------------------------------
module lcd_dma
    import sv_pkg::*;
#(
    parameter int VRAM_AW = 13
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic               reg_cs,
    input  logic               reg_we,
    input  logic [2:0]         reg_addr,
    input  logic [7:0]         reg_din,
    output logic [7:0]         reg_dout,
    output logic               busy,
    output logic               done,
    output logic [15:0]        mem_addr,
    output logic               mem_rd,
    input  logic [7:0]         mem_din,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_dout,
    output logic               vram_we
);

    dma_state_e         state_q;
    logic [12:0]        cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               mem_rd_q;
    logic [15:0]        mem_addr_q;
    logic               vram_we_q;
    logic [VRAM_AW-1:0] vram_addr_q;
    logic [7:0]         vram_dout_q;

    logic               idle_s;
    logic               step_s;
    logic               start_s;
    logic [15:0]        src_s;
    logic [VRAM_AW-1:0] vram_dst_s;
    logic [7:0]         len_s;

    assign idle_s = (state_q == IDLE);
    assign step_s = ce & (state_q == WRITE);

    lcd_dma_regs #(
        .VRAM_AW (VRAM_AW)
    ) u_regs (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .ce_i       (ce),
        .reg_cs_i   (reg_cs),
        .reg_we_i   (reg_we),
        .reg_addr_i (reg_addr),
        .reg_din_i  (reg_din),
        .idle_i     (idle_s),
        .busy_i     (busy_q),
        .step_i     (step_s),
        .src_o      (src_s),
        .vram_dst_o (vram_dst_s),
        .len_o      (len_s),
        .start_o    (start_s),
        .reg_dout_o (reg_dout)
    );

    // Transfer FSM with registered bus/VRAM outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 13'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            vram_we_q   <= 1'b0;
            vram_addr_q <= '0;
            vram_dout_q <= 8'h00;
        end else begin
            // vram_we and done are single-clk pulses even when ce is sparse.
            vram_we_q <= 1'b0;
            done_q    <= 1'b0;
            if (ce) begin
                case (state_q)
                    IDLE: begin
                        if (start_s) begin
                            cnt_q      <= byte_count(len_s);
                            busy_q     <= 1'b1;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= src_s;
                            state_q    <= READ;
                        end
                    end
                    READ: begin
                        mem_rd_q <= 1'b0;
                        state_q  <= CAPTURE;
                    end
                    CAPTURE: begin
                        vram_dout_q <= mem_din;
                        vram_addr_q <= vram_dst_s;
                        vram_we_q   <= 1'b1;
                        state_q     <= WRITE;
                    end
                    WRITE: begin
                        // src/dst advance in the register file on this same tick,
                        // so the next read address is src+1.
                        cnt_q <= cnt_q - 13'd1;
                        if (cnt_q == 13'd1) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= src_s + 16'd1;
                            state_q    <= READ;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        busy_q   <= 1'b0;
                        mem_rd_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign vram_we   = vram_we_q;
    assign vram_addr = vram_addr_q;
    assign vram_dout = vram_dout_q;

endmodule

// File: tb/tb_lcd_dma.sv
// ---------------------------------------------------------------------------
// tb_lcd_dma: scoreboard bench for lcd_dma. Expected VRAM writes (and, for
// the wrap case, bus read addresses) are queued when a transfer is started
// and popped as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_lcd_dma;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic        reg_cs = 1'b0;
    logic        reg_we = 1'b0;
    logic [2:0]  reg_addr = 3'd0;
    logic [7:0]  reg_din = 8'h00;
    logic [7:0]  reg_dout;
    logic        busy;
    logic        done;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_din = 8'h00;
    logic [12:0] vram_addr;
    logic [7:0]  vram_dout;
    logic        vram_we;

    lcd_dma #(.VRAM_AW(13)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .reg_cs    (reg_cs),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_din   (reg_din),
        .reg_dout  (reg_dout),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_din   (mem_din),
        .vram_addr (vram_addr),
        .vram_dout (vram_dout),
        .vram_we   (vram_we)
    );

    always #5 clk = ~clk;

    // System memory model: returns the low address byte on the ce tick after a read.
    always @(posedge clk) begin
        if (ce && mem_rd) mem_din <= mem_addr[7:0];
    end

    int          n_cmp = 0;
    int          n_err = 0;
    logic [20:0] vram_q[$];
    logic [15:0] mem_q[$];
    bit          chk_mem = 1'b0;
    bit          ce_gate = 1'b0;
    int          we_clks = 0;
    int          busy_ticks = 0;
    int          busy_clks = 0;
    int          done_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ce generator: constant 1, or high one clk in four.
    initial begin
        logic [1:0] div;
        div = 2'd0;
        forever begin
            @(negedge clk);
            if (ce_gate) begin
                div = div + 2'd1;
                ce  = (div == 2'd0);
            end else begin
                ce  = 1'b1;
            end
        end
    end

    // Output monitor / scoreboard consumer.
    initial begin
        logic [20:0] e;
        logic [15:0] m;
        logic        rd_prev;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (vram_we) begin
                we_clks++;
                check_eq("vram_q_nonempty", 32'(vram_q.size() > 0), 32'd1);
                if (vram_q.size() > 0) begin
                    e = vram_q.pop_front();
                    check_eq("vram_addr", 32'(vram_addr), 32'(e[20:8]));
                    check_eq("vram_data", 32'(vram_dout), 32'(e[7:0]));
                end
            end
            if (chk_mem && mem_rd && !rd_prev) begin
                check_eq("mem_q_nonempty", 32'(mem_q.size() > 0), 32'd1);
                if (mem_q.size() > 0) begin
                    m = mem_q.pop_front();
                    check_eq("mem_addr", 32'(mem_addr), 32'(m));
                end
            end
            rd_prev = mem_rd;
            if (busy && ce) busy_ticks++;
            if (busy) busy_clks++;
            if (done) done_cnt++;
        end
    end

    task automatic clear_counts();
        we_clks    = 0;
        busy_ticks = 0;
        busy_clks  = 0;
        done_cnt   = 0;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_cs   = 1'b1;
        reg_we   = 1'b1;
        reg_addr = a;
        reg_din  = d;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            if (ce) break;
        end
        @(negedge clk);
        reg_cs = 1'b0;
        reg_we = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        reg_addr = a;
        #1;
        d = reg_dout;
    endtask

    task automatic read16(input logic [2:0] a_lo, output logic [15:0] v);
        logic [7:0] lo, hi;
        reg_read(a_lo, lo);
        reg_read(a_lo + 3'd1, hi);
        v = {hi, lo};
    endtask

    task automatic start_xfer(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] len);
        reg_write(3'd0, src[7:0]);
        reg_write(3'd1, src[15:8]);
        reg_write(3'd2, dst[7:0]);
        reg_write(3'd3, dst[15:8]);
        reg_write(3'd4, len);
        reg_write(3'd5, 8'h80);
    endtask

    // Queue the writes a transfer should produce (memory data = source low byte).
    task automatic push_exp(input logic [15:0] src, input logic [15:0] dst, input int nbytes);
        logic [12:0] a;
        logic [15:0] s;
        for (int i = 0; i < nbytes; i++) begin
            a = dst[12:0] + 13'(i);
            s = src + 16'(i);
            vram_q.push_back({a, s[7:0]});
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        repeat (10) @(negedge clk);
        check_eq(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        logic [7:0]  d;
        logic [15:0] v;
        int          d0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
        check_eq("rst_vram_we", 32'(vram_we), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_vram_addr", 32'(vram_addr), 32'd0);
        check_eq("rst_vram_dout", 32'(vram_dout), 32'd0);
        for (int i = 0; i < 8; i++) begin
            reg_read(3'(i), d);
            check_eq("rst_reg", 32'(d), 32'd0);
        end

        // Single-unit copy
        clear_counts();
        push_exp(16'h1000, 16'h4000, 16);
        start_xfer(16'h1000, 16'h4000, 8'd1);
        wait_done("t1_done", 200);
        check_eq("t1_busy_ticks", 32'(busy_ticks), 32'd48);
        check_eq("t1_writes", 32'(we_clks), 32'd16);
        read16(3'd0, v);
        check_eq("t1_src", 32'(v), 32'h1010);
        read16(3'd2, v);
        check_eq("t1_dst", 32'(v), 32'h4010);
        check_eq("t1_q_left", 32'(vram_q.size()), 32'd0);

        // Start with bit7 clear does nothing
        clear_counts();
        reg_write(3'd5, 8'h7F);
        repeat (12) @(negedge clk);
        check_eq("nostart_busy", 32'(busy_clks), 32'd0);
        check_eq("nostart_writes", 32'(we_clks), 32'd0);

        // Wrap-around of src and dst
        clear_counts();
        push_exp(16'hFFF8, 16'h5FF8, 16);
        for (int i = 0; i < 16; i++) mem_q.push_back(16'hFFF8 + 16'(i));
        chk_mem = 1'b1;
        start_xfer(16'hFFF8, 16'h5FF8, 8'd1);
        wait_done("wrap_done", 200);
        chk_mem = 1'b0;
        read16(3'd2, v);
        check_eq("wrap_dst", 32'(v), 32'h4008);
        read16(3'd0, v);
        check_eq("wrap_src", 32'(v), 32'h0008);
        check_eq("wrap_mem_left", 32'(mem_q.size()), 32'd0);

        // ce gating: one ce per four clks
        ce_gate = 1'b1;
        clear_counts();
        push_exp(16'h1000, 16'h0100, 16);
        start_xfer(16'h1000, 16'h0100, 8'd1);
        wait_done("ce_done", 600);
        check_eq("ce_busy_ticks", 32'(busy_ticks), 32'd48);
        check_eq("ce_busy_clks", 32'(busy_clks), 32'd192);
        check_eq("ce_we_clks", 32'(we_clks), 32'd16);
        ce_gate = 1'b0;
        repeat (8) @(negedge clk);

        // Busy lockout
        clear_counts();
        push_exp(16'h1030, 16'h0200, 16);
        start_xfer(16'h1030, 16'h0200, 8'd1);
        repeat (4) @(negedge clk);
        reg_read(3'd5, d);
        check_eq("lock_ctrl_busy", 32'(d), 32'h80);
        reg_write(3'd0, 8'h22);
        reg_write(3'd1, 8'h22);
        reg_write(3'd5, 8'h80);
        wait_done("lock_done", 200);
        repeat (20) @(negedge clk);
        check_eq("lock_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("lock_writes", 32'(we_clks), 32'd16);
        check_eq("lock_busy_ticks", 32'(busy_ticks), 32'd48);
        read16(3'd0, v);
        check_eq("lock_src", 32'(v), 32'h1040);
        reg_read(3'd5, d);
        check_eq("lock_ctrl_idle", 32'(d), 32'h00);

        // len = 0 means 256 units
        clear_counts();
        push_exp(16'h0000, 16'h0000, 4096);
        start_xfer(16'h0000, 16'h0000, 8'd0);
        wait_done("len0_done", 13000);
        check_eq("len0_writes", 32'(we_clks), 32'd4096);
        check_eq("len0_busy_ticks", 32'(busy_ticks), 32'd12288);

        // Reset mid-transfer
        clear_counts();
        push_exp(16'h1000, 16'h0300, 16);
        start_xfer(16'h1000, 16'h0300, 8'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (we_clks >= 5) break;
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_vram_we", 32'(vram_we), 32'd0);
        check_eq("mid_mem_rd", 32'(mem_rd), 32'd0);
        for (int i = 0; i < 6; i++) begin
            reg_read(3'(i), d);
            check_eq("mid_reg", 32'(d), 32'd0);
        end
        vram_q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("mid_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("mid_writes", 32'(we_clks), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
